// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds WIDTH-bit operands one nibble per clock through a 4-bit lookahead slice.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             cr;
    logic [CW-1:0]    cnt;
    logic [3:0]       g, p, c, s;
    always_comb begin
        g    = a_sr[3:0] & b_sr[3:0];
        p    = a_sr[3:0] ^ b_sr[3:0];
        c[0] = g[0] | p[0] & cr;
        c[1] = g[1] | p[1] & g[0] | p[1] & p[0] & cr;
        c[2] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & cr;
        c[3] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
             | p[3] & p[2] & p[1] & p[0] & cr;
        s    = p ^ {c[2:0], cr};
    end
    // sum doubles as the result shift register; it only changes while in CALC
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            cr        <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sr     <= a_in;
                    b_sr     <= b_in;
                    cr       <= c_in;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= CALC;
                end
                CALC: begin
                    a_sr <= a_sr >> 4;
                    b_sr <= b_sr >> 4;
                    sum  <= {s, sum[WIDTH-1:4]};
                    cr   <= c[3];
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        co        <= c[3];
`ifdef OVERFLOW_FLAG_EN
                        ovf       <= c[2] ^ c[3];
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: vector table plus scoreboard bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;
    typedef struct {
        logic [15:0] a, b;
        logic        ci;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;

    logic        clk = 0, rst = 1, in_valid = 0, in_ready, c_in = 0;
    logic        out_valid, out_ready = 1, co;
    logic [15:0] a_in = 0, b_in = 0, sum;
`ifdef OVERFLOW_FLAG_EN
    logic        ovf;
`endif
    int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    logic ov_q = 0;
    vec_t sb[$];
    vec_t tbl[8];

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .co(co)
`ifdef OVERFLOW_FLAG_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic vec_t model(logic [15:0] a, logic [15:0] b, logic ci);
        vec_t v;
        logic [16:0] r;
        r = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        v.a = a; v.b = b; v.ci = ci; v.s = r[15:0]; v.co = r[16];
        v.ov = (a[15] == b[15]) && (r[15] != a[15]);
        return v;
    endfunction

    function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic ci,
                                logic [15:0] s, logic c, logic o);
        vec_t v;
        v.a = a; v.b = b; v.ci = ci; v.s = s; v.co = c; v.ov = o;
        return v;
    endfunction

    // output side of the scoreboard, plus accept-to-valid latency
    always @(negedge clk) begin
        if (rst) ov_q = 0;
        else begin
            if (out_valid && !ov_q) chk("latency", cyc - acc_cyc, 5);
            ov_q = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("sum", {16'b0, sum}, {16'b0, e.s});
                    chk("co", {31'b0, co}, {31'b0, e.co});
`ifdef OVERFLOW_FLAG_EN
                    chk("ovf", {31'b0, ovf}, {31'b0, e.ov});
`endif
                end
            end
        end
    end

    task automatic send(input vec_t e);
        int t;
        @(posedge clk); #1;
        in_valid = 1; a_in = e.a; b_in = e.b; c_in = e.ci;
        t = 0;
        do begin @(negedge clk); t++; end while (!in_ready && t < 50);
        if (!in_ready) chk("accept_timeout", 0, 1);
        else begin
            sb.push_back(e);
            acc_cyc = cyc;
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t ops[3];
        int acc[3];
        int t;
        tbl[0] = mk(16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
        tbl[1] = mk(16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0);
        tbl[2] = mk(16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
        tbl[3] = mk(16'h8000, 16'hFFFF, 0, 16'h7FFF, 1, 1);
        tbl[4] = mk(16'h00F0, 16'h0010, 0, 16'h0100, 0, 0);
        tbl[5] = mk(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0);
        tbl[6] = mk(16'h0F0F, 16'h00F1, 1, 16'h1001, 0, 0);
        tbl[7] = mk(16'hA5A5, 16'h5A5A, 0, 16'hFFFF, 0, 0);

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_sum", {16'b0, sum}, 0);
        chk("rst_co", {31'b0, co}, 0);

        for (int i = 0; i < 8; i++) send(tbl[i]);
        for (int i = 0; i < 4; i++)
            send(model(16'($urandom), 16'($urandom), 1'($urandom)));
        drain();

        // backpressure: result must hold while the consumer stalls
        out_ready = 0;
        send(mk(16'h8000, 16'h8000, 0, 16'h0000, 1, 1));
        t = 0;
        while (!out_valid && t < 20) begin @(negedge clk); t++; end
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 1);
            chk("bp_sum", {16'b0, sum}, 0);
            chk("bp_co", {31'b0, co}, 1);
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1;
        drain();

        // reset two edges after accept aborts the operation
        @(posedge clk); #1;
        in_valid = 1; a_in = 16'h1111; b_in = 16'h2222; c_in = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!in_ready && t < 50);
        @(posedge clk); #1 in_valid = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_out_valid", {31'b0, out_valid}, 0);
        end
        chk("abort_sum", {16'b0, sum}, 0);
        chk("abort_co", {31'b0, co}, 0);
        chk("abort_in_ready", {31'b0, in_ready}, 1);
        send(mk(16'h0001, 16'h0001, 0, 16'h0002, 0, 0));
        drain();

        // back-to-back with in_valid held high
        ops[0] = model(16'h0101, 16'h0202, 0);
        ops[1] = model(16'hFFF0, 16'h0011, 0);
        ops[2] = model(16'h4000, 16'h4000, 1);
        @(posedge clk); #1;
        in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            a_in = ops[k].a; b_in = ops[k].b; c_in = ops[k].ci;
            t = 0;
            do begin @(negedge clk); t++; end while (!in_ready && t < 50);
            if (!in_ready) chk("b2b_accept_timeout", 0, 1);
            else begin
                sb.push_back(ops[k]);
                acc_cyc = cyc;
            end
            acc[k] = cyc;
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("b2b_spacing0", acc[1] - acc[0], 6);
        chk("b2b_spacing1", acc[2] - acc[1], 6);
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
